// File: rtl/memc_wr_buffer.sv
// memc_wr_buffer: first-word-fall-through write-command FIFO from blake2b to the memory-controller write port.
// Optional MEMC_WR_ALIGN_CHECK_EN: writes with waddr[4:0]!=0 are dropped and flag sticky align_err.
module memc_wr_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic         eclk,
  input  logic         rst,
  input  logic         wvalid,
  input  logic [255:0] wdata,
  input  logic [3:0]   wtag,
  input  logic [31:0]  waddr,
  output logic         memc_cmd_full,
  output logic         mc_valid,
  input  logic         mc_ready,
  output logic [255:0] mc_data,
  output logic [3:0]   mc_tag,
  output logic [31:0]  mc_addr,
  output logic [AW:0]  level,
  output logic         overflow
`ifdef MEMC_WR_ALIGN_CHECK_EN
  ,
  output logic         align_err
`endif
);
  localparam int unsigned DW       = 256 + 4 + 32;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_L = (AW+1)'(DEPTH - FULL_MARGIN);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] out_q, out_d;
  logic          mc_valid_q, mc_valid_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          align_err_q, align_err_d;
  logic          accept_c, push_c, pop_c, out_free_c, ram_empty_c, ram_rd_c, ram_wr_c;
  logic [DW-1:0] win_c;

  // Output register refills from RAM first; an empty RAM lets a new write bypass straight in.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_d       = out_q;
    mc_valid_d  = mc_valid_q;
    align_err_d = align_err_q;
    win_c       = {wdata, wtag, waddr};
    accept_c    = wvalid;
`ifdef MEMC_WR_ALIGN_CHECK_EN
    accept_c    = wvalid & (waddr[4:0] == 5'd0);
    align_err_d = align_err_q | (wvalid & (waddr[4:0] != 5'd0));
`endif
    pop_c       = mc_valid_q & mc_ready;
    push_c      = accept_c & ((level_q < DEPTH_L) | pop_c);
    out_free_c  = ~mc_valid_q | pop_c;
    ram_empty_c = (level_q == (AW+1)'(mc_valid_q));
    ram_rd_c    = out_free_c & ~ram_empty_c;
    ram_wr_c    = push_c & ~(out_free_c & ram_empty_c);

    if (out_free_c) begin
      if (!ram_empty_c) begin
        out_d      = mem_q[rd_ptr_q];
        mc_valid_d = 1'b1;
      end else if (push_c) begin
        out_d      = win_c;
        mc_valid_d = 1'b1;
      end else begin
        mc_valid_d = 1'b0;
      end
    end
    if (ram_rd_c) rd_ptr_d = rd_ptr_q + AW'(1);
    if (ram_wr_c) wr_ptr_d = wr_ptr_q + AW'(1);

    level_d    = level_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
    full_d     = (level_d >= THRESH_L);
    overflow_d = overflow_q | (wvalid & (level_q == DEPTH_L) & ~pop_c);
  end

  // Storage array carries no reset; only pointers and occupancy define its contents.
  always_ff @(posedge eclk) begin
    if (ram_wr_c) mem_q[wr_ptr_q] <= win_c;
  end

  always_ff @(posedge eclk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_q       <= '0;
      mc_valid_q  <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_q       <= out_d;
      mc_valid_q  <= mc_valid_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      align_err_q <= align_err_d;
    end
  end

  assign {mc_data, mc_tag, mc_addr} = out_q;
  assign mc_valid      = mc_valid_q;
  assign level         = level_q;
  assign memc_cmd_full = full_q;
  assign overflow      = overflow_q;
`ifdef MEMC_WR_ALIGN_CHECK_EN
  assign align_err     = align_err_q;
`else
  logic unused_align_c;
  assign unused_align_c = align_err_d;
`endif

endmodule

// File: tb/tb_memc_wr_buffer.sv
// Bench for memc_wr_buffer: vector table, hand-written corner sequences and random traffic against a queue model.
module tb_memc_wr_buffer;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;

  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   tag;
    logic [31:0]  addr;
  } cmd_t;

  typedef struct {
    logic r;
    logic wv;
    cmd_t c;
    logic rdy;
    int   exp_level;
    logic exp_valid;
    logic exp_full;
    logic exp_ovf;
  } vec_t;

  logic         eclk = 1'b0;
  logic         rst, wvalid, mc_ready;
  logic [255:0] wdata;
  logic [3:0]   wtag;
  logic [31:0]  waddr;
  logic         memc_cmd_full, mc_valid, overflow;
  logic [255:0] mc_data;
  logic [3:0]   mc_tag;
  logic [31:0]  mc_addr;
  logic [4:0]   level;
`ifdef MEMC_WR_ALIGN_CHECK_EN
  logic         align_err;
`endif

  memc_wr_buffer dut (
    .eclk(eclk), .rst(rst), .wvalid(wvalid), .wdata(wdata), .wtag(wtag), .waddr(waddr),
    .memc_cmd_full(memc_cmd_full), .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_data(mc_data), .mc_tag(mc_tag), .mc_addr(mc_addr), .level(level), .overflow(overflow)
`ifdef MEMC_WR_ALIGN_CHECK_EN
    , .align_err(align_err)
`endif
  );

  always #5 eclk = ~eclk;

  cmd_t q[$];
  logic m_ovf, m_full, m_aerr;
  int   n_tests, n_fail, n_out;
  vec_t vt[$];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input int k);
    cmd_t c;
    c.data = {8{32'hC0DE_0000 + 32'(k)}};
    c.tag  = 4'(k);
    c.addr = 32'h5A00_0000 + (32'(k) << 5);
    return c;
  endfunction

  function automatic cmd_t rnd(input logic aligned);
    cmd_t c;
    c.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    c.tag  = 4'($urandom);
    c.addr = $urandom;
    if (aligned) c.addr[4:0] = 5'd0;
    return c;
  endfunction

  // One clock: model the FIFO by its rules, then compare the DUT just after the edge.
  task automatic cycle(input logic r, input logic wv, input cmd_t c, input logic rdy);
    logic pop, push, ok;
    rst = r; wvalid = wv; wdata = c.data; wtag = c.tag; waddr = c.addr; mc_ready = rdy;
    ok = 1'b1;
`ifdef MEMC_WR_ALIGN_CHECK_EN
    ok = (c.addr[4:0] == 5'd0);
`endif
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_aerr = 1'b0;
    end else begin
      pop  = (q.size() > 0) && rdy;
      push = wv && ok && ((q.size() < DEPTH) || pop);
      if (wv && (q.size() == DEPTH) && !pop) m_ovf = 1'b1;
      if (wv && !ok) m_aerr = 1'b1;
      if (pop) begin
        void'(q.pop_front());
        n_out++;
      end
      if (push) q.push_back(c);
    end
    m_full = (q.size() >= THRESH);
    @(posedge eclk);
    #1;
    chk("level", 320'(level), 320'(q.size()));
    chk("mc_valid", 320'(mc_valid), 320'(q.size() > 0));
    chk("memc_cmd_full", 320'(memc_cmd_full), 320'(m_full));
    chk("overflow", 320'(overflow), 320'(m_ovf));
    if (q.size() > 0) chk("mc_cmd_head", 320'({mc_data, mc_tag, mc_addr}), 320'(q[0]));
    if (r) chk("mc_cmd_reset", 320'({mc_data, mc_tag, mc_addr}), 320'(0));
`ifdef MEMC_WR_ALIGN_CHECK_EN
    chk("align_err", 320'(align_err), 320'(m_aerr));
`endif
  endtask

  task automatic add(input logic r, input logic wv, input cmd_t c, input logic rdy,
                     input int lvl, input logic v, input logic f, input logic o);
    vec_t e;
    e.r = r; e.wv = wv; e.c = c; e.rdy = rdy;
    e.exp_level = lvl; e.exp_valid = v; e.exp_full = f; e.exp_ovf = o;
    vt.push_back(e);
  endtask

  initial begin
    cmd_t z, t1;
    int   start, writes, guard;
    n_tests = 0; n_fail = 0; n_out = 0;
    m_ovf = 1'b0; m_full = 1'b0; m_aerr = 1'b0;
    z = '0;
    t1.data = {32{8'hA5}}; t1.tag = 4'h3; t1.addr = 32'h5A00_0000;
    rst = 1'b1; wvalid = 1'b0; mc_ready = 1'b0; wdata = '0; wtag = '0; waddr = '0;
    @(posedge eclk);
    #1;

    // Table: reset, single write, burst-to-overflow, full with simultaneous pop, drain.
    add(1, 0, z, 0, 0, 0, 0, 0);
    add(1, 0, z, 0, 0, 0, 0, 0);
    add(0, 1, t1, 1, 1, 1, 0, 0);
    add(0, 0, z, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(0, 1, mk(k), 0, k, 1, k >= THRESH, 0);
    add(0, 1, mk(17), 0, 16, 1, 1, 1);
    add(1, 0, z, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(0, 1, mk(20 + k), 0, k, 1, k >= THRESH, 0);
    add(0, 1, mk(40), 1, 16, 1, 1, 0);
    for (int j = 1; j <= 16; j++) add(0, 0, z, 1, 16 - j, (16 - j) > 0, (16 - j) >= THRESH, 0);
    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].wv, vt[i].c, vt[i].rdy);
      chk("tbl_level", 320'(level), 320'(vt[i].exp_level));
      chk("tbl_valid", 320'(mc_valid), 320'(vt[i].exp_valid));
      chk("tbl_full", 320'(memc_cmd_full), 320'(vt[i].exp_full));
      chk("tbl_ovf", 320'(overflow), 320'(vt[i].exp_ovf));
    end

    // Reset with 9 buffered, then a normal write.
    cycle(1, 0, z, 0);
    for (int k = 1; k <= 9; k++) cycle(0, 1, mk(50 + k), 0);
    chk("rst9_level_before", 320'(level), 320'(9));
    cycle(1, 1, mk(60), 1);
    chk("rst9_level", 320'(level), 320'(0));
    chk("rst9_valid", 320'(mc_valid), 320'(0));
    chk("rst9_full", 320'(memc_cmd_full), 320'(0));
    cycle(0, 1, mk(61), 1);
    chk("rst9_after_valid", 320'(mc_valid), 320'(1));
    chk("rst9_after_addr", 320'(mc_addr), 320'(32'h5A00_07A0));
    cycle(0, 0, z, 1);
    chk("rst9_after_drain", 320'(level), 320'(0));

`ifdef MEMC_WR_ALIGN_CHECK_EN
    t1.addr = 32'h5A00_0010;
    cycle(0, 1, t1, 1);
    chk("align_drop_valid", 320'(mc_valid), 320'(0));
    chk("align_err_set", 320'(align_err), 320'(1));
    t1.addr = 32'h5A00_0020;
    cycle(0, 1, t1, 1);
    chk("align_ok_addr", 320'(mc_addr), 320'(32'h5A00_0020));
`endif

    // 200 writes, producer honours memc_cmd_full, random consumer.
    cycle(1, 0, z, 0);
    start = n_out; writes = 0; guard = 0;
    while (writes < 200 && guard < 5000) begin
      logic wv;
      wv = !memc_cmd_full && ($urandom_range(0, 1) == 1);
      cycle(0, wv, rnd(1'b1), $urandom_range(0, 1) == 1);
      if (wv) writes++;
      guard++;
    end
    while (q.size() > 0 && guard < 6000) begin
      cycle(0, 0, rnd(1'b1), 1);
      guard++;
    end
    chk("rand_bound", 320'(guard < 6000), 320'(1));
    chk("rand_all_out", 320'(n_out - start), 320'(200));
    chk("rand_no_ovf", 320'(overflow), 320'(0));

    // Aggressive producer ignoring backpressure: overflow and full-with-pop paths.
    cycle(1, 0, z, 0);
    for (int i = 0; i < 400; i++)
      cycle(0, $urandom_range(0, 3) != 0, rnd($urandom_range(0, 3) != 0), $urandom_range(0, 9) < 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
